// File: rtl/control_sel_pkg.sv
// Shared select/state types for the single-cycle datapath.
// Holds the request-unit FSM state encoding and latched memory request.
package control_sel_pkg;

  typedef enum logic [1:0] {
    RU_FETCH = 2'b00,
    RU_DATA  = 2'b01,
    RU_HALT  = 2'b10
  } ru_state_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } ru_req_t;

  localparam ru_req_t RU_REQ_NONE = '{rd: 1'b0, wr: 1'b0};

  function automatic logic ru_is_mem(
    input logic rd,
    input logic wr
  );
    return rd | wr;
  endfunction

endpackage

// File: rtl/request_unit_if.sv
// Datapath-to-cache request/hit signals for the request unit.
// master = request unit, slave = cache side.
interface request_unit_if;

  logic ihit;
  logic dhit;
  logic imemREN;
  logic dmemREN;
  logic dmemWEN;

  modport master (
    input  ihit,
    input  dhit,
    output imemREN,
    output dmemREN,
    output dmemWEN
  );

  modport slave (
    output ihit,
    output dhit,
    input  imemREN,
    input  dmemREN,
    input  dmemWEN
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the request unit's performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic w_full;

  assign w_full = &cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && !w_full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/request_unit.sv
// Sequences fetch, data access and halt between the datapath and cache.
// Memory strobes come from registered state only; retire pulses are combinational.
module request_unit
  import control_sel_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  request_unit_if.master    dcif,
  input  logic              cu_dREN,
  input  logic              cu_dWEN,
  input  logic              cu_halt,
  output logic              pc_en,
  output logic              rf_wen_ok,
  output logic              halt,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  ru_state_t r_state;
  ru_state_t w_next;
  ru_req_t   r_req;
  ru_req_t   w_req_next;

  logic w_retire;
  logic w_halt_entry;
  logic w_stall;
  logic w_instr_inc;

  always_comb begin
    w_next       = r_state;
    w_req_next   = r_req;
    w_retire     = 1'b0;
    w_halt_entry = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      RU_FETCH: begin
        if (dcif.ihit) begin
          if (cu_halt) begin
            w_next       = RU_HALT;
            w_halt_entry = 1'b1;
          end else if (ru_is_mem(cu_dREN, cu_dWEN)) begin
            w_next     = RU_DATA;
            w_req_next = '{rd: cu_dREN, wr: cu_dWEN};
          end else begin
            w_retire = 1'b1;
          end
        end else begin
          w_stall = 1'b1;
        end
      end
      RU_DATA: begin
        if (dcif.dhit) begin
          w_retire   = 1'b1;
          w_req_next = RU_REQ_NONE;
          w_next     = RU_FETCH;
        end else begin
          w_stall = 1'b1;
        end
      end
      RU_HALT: begin
        w_next = RU_HALT;
      end
      default: begin
        w_next     = RU_FETCH;
        w_req_next = RU_REQ_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RU_FETCH;
      r_req   <= RU_REQ_NONE;
    end else begin
      r_state <= w_next;
      r_req   <= w_req_next;
    end
  end

  // Both strobes may assert together; that upstream error is passed through.
  assign dcif.imemREN = (r_state == RU_FETCH);
  assign dcif.dmemREN = (r_state == RU_DATA) & r_req.rd;
  assign dcif.dmemWEN = (r_state == RU_DATA) & r_req.wr;
  assign halt         = (r_state == RU_HALT);

  assign pc_en     = w_retire;
  assign rf_wen_ok = w_retire;

  assign w_instr_inc = w_retire | w_halt_entry;

  sat_counter #(
    .W (CNT_W)
  ) u_instr_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (w_instr_inc),
    .cnt  (instr_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (w_stall),
    .cnt  (stall_cnt)
  );

endmodule
